// File: rtl/boe_sched.sv
// boe_sched: round-robin front end that shares one sum/extreme/sort
// engine between two frame requesters and tags its result stream.
module boe_sched #(
  parameter int RES_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [2:0]  req0_num,
  input  logic [2:0]  req1_num,
  input  logic [7:0]  req0_data,
  input  logic [7:0]  req1_data,
  output logic        req0_rd,
  output logic        req1_rd,
  output logic        req0_err,
  output logic        req1_err,
  output logic        eng_start,
  output logic [2:0]  eng_num,
  output logic [7:0]  eng_data,
  input  logic [10:0] eng_result,
  output logic        res_valid,
  output logic        res_id,
  output logic [1:0]  res_kind,
  output logic [2:0]  res_idx,
  output logic [10:0] res_data,
  output logic        res_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_DRAIN
  } state_t;

  localparam logic [7:0] WAIT_END = 8'(RES_LAT - 2);

  state_t      r_state;
  logic        r_last;
  logic        r_id;
  logic [2:0]  r_num;
  logic [7:0]  r_cnt;
  logic        r_err0;
  logic        r_err1;
  logic        r_res_valid;
  logic        r_res_id;
  logic [1:0]  r_res_kind;
  logic [2:0]  r_res_idx;
  logic [10:0] r_res_data;
  logic        r_res_last;

  logic        w_v0;
  logic        w_v1;
  logic        w_any;
  logic        w_pick;
  logic [2:0]  w_pnum;
  logic        w_legal;
  logic        w_feed;
  logic [7:0]  w_n_m1;
  logic [7:0]  w_n_p1;
  logic [1:0]  w_kind;
  logic [2:0]  w_idx;

  // a requester whose err is showing is masked so it can drop valid
  assign w_v0    = req0_valid & ~r_err0;
  assign w_v1    = req1_valid & ~r_err1;
  assign w_any   = w_v0 | w_v1;
  assign w_pick  = (w_v0 & w_v1) ? ~r_last : w_v1;
  assign w_pnum  = w_pick ? req1_num : req0_num;
  assign w_legal = (w_pnum >= 3'd2) && (w_pnum <= 3'd6);

  assign w_feed  = (r_state == S_FEED);
  assign w_n_m1  = {5'd0, r_num} - 8'd1;
  assign w_n_p1  = {5'd0, r_num} + 8'd1;

  always_comb begin
    w_kind = 2'd2;
    w_idx  = r_cnt[2:0] - 3'd2;
    unique case (1'b1)
      (r_cnt == 8'd0): begin
        w_kind = 2'd0;
        w_idx  = 3'd0;
      end
      (r_cnt == 8'd1): begin
        w_kind = 2'd1;
        w_idx  = 3'd0;
      end
      default: ;
    endcase
  end

  assign req0_rd   = w_feed & ~r_id;
  assign req1_rd   = w_feed & r_id;
  assign eng_start = w_feed & (r_cnt == 8'd0);
  assign eng_num   = r_num;
  assign eng_data  = w_feed ? (r_id ? req1_data : req0_data) : 8'd0;

  assign req0_err  = r_err0;
  assign req1_err  = r_err1;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_kind  = r_res_kind;
  assign res_idx   = r_res_idx;
  assign res_data  = r_res_data;
  assign res_last  = r_res_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_num       <= 3'd0;
      r_cnt       <= 8'd0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_kind  <= 2'd0;
      r_res_idx   <= 3'd0;
      r_res_data  <= 11'd0;
      r_res_last  <= 1'b0;
    end else begin
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_kind  <= 2'd0;
      r_res_idx   <= 3'd0;
      r_res_data  <= 11'd0;
      r_res_last  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            if (!w_legal) begin
              if (w_pick) r_err1 <= 1'b1;
              else        r_err0 <= 1'b1;
            end else begin
              r_id    <= w_pick;
              r_last  <= w_pick;
              r_num   <= w_pnum;
              r_cnt   <= 8'd0;
              r_state <= S_FEED;
            end
          end
        end
        S_FEED: begin
          if (r_cnt == w_n_m1) begin
            r_cnt   <= 8'd0;
            r_state <= (RES_LAT > 1) ? S_WAIT : S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (r_cnt == WAIT_END) begin
            r_cnt   <= 8'd0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          r_res_valid <= 1'b1;
          r_res_id    <= r_id;
          r_res_kind  <= w_kind;
          r_res_idx   <= w_idx;
          r_res_data  <= eng_result;
          if (r_cnt == w_n_p1) begin
            r_res_last <= 1'b1;
            r_cnt      <= 8'd0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boe_sched.sv
// tb_boe_sched: directed checks of boe_sched with a behavioural engine,
// RES_LAT=2 on instance a and RES_LAT=1 on instance b.
module tb_boe_sched;

  typedef struct {
    int          cyc;
    logic        id;
    logic [1:0]  kind;
    logic [2:0]  idx;
    logic [10:0] data;
    logic        last;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance a signals
  logic        a_req0_valid, a_req1_valid;
  logic [2:0]  a_req0_num, a_req1_num;
  logic [7:0]  a_req0_data, a_req1_data;
  logic        a_req0_rd, a_req1_rd, a_req0_err, a_req1_err;
  logic        a_eng_start;
  logic [2:0]  a_eng_num;
  logic [7:0]  a_eng_data;
  logic [10:0] a_eng_result = '0;
  logic        a_res_valid, a_res_id, a_res_last;
  logic [1:0]  a_res_kind;
  logic [2:0]  a_res_idx;
  logic [10:0] a_res_data;

  // instance b signals
  logic        b_req0_valid, b_req1_valid;
  logic [2:0]  b_req0_num, b_req1_num;
  logic [7:0]  b_req0_data, b_req1_data;
  logic        b_req0_rd, b_req1_rd, b_req0_err, b_req1_err;
  logic        b_eng_start;
  logic [2:0]  b_eng_num;
  logic [7:0]  b_eng_data;
  logic [10:0] b_eng_result = '0;
  logic        b_res_valid, b_res_id, b_res_last;
  logic [1:0]  b_res_kind;
  logic [2:0]  b_res_idx;
  logic [10:0] b_res_data;

  boe_sched #(.RES_LAT(2)) u_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_req0_valid), .req1_valid(a_req1_valid),
    .req0_num(a_req0_num), .req1_num(a_req1_num),
    .req0_data(a_req0_data), .req1_data(a_req1_data),
    .req0_rd(a_req0_rd), .req1_rd(a_req1_rd),
    .req0_err(a_req0_err), .req1_err(a_req1_err),
    .eng_start(a_eng_start), .eng_num(a_eng_num),
    .eng_data(a_eng_data), .eng_result(a_eng_result),
    .res_valid(a_res_valid), .res_id(a_res_id),
    .res_kind(a_res_kind), .res_idx(a_res_idx),
    .res_data(a_res_data), .res_last(a_res_last)
  );

  boe_sched #(.RES_LAT(1)) u_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req1_valid(b_req1_valid),
    .req0_num(b_req0_num), .req1_num(b_req1_num),
    .req0_data(b_req0_data), .req1_data(b_req1_data),
    .req0_rd(b_req0_rd), .req1_rd(b_req1_rd),
    .req0_err(b_req0_err), .req1_err(b_req1_err),
    .eng_start(b_eng_start), .eng_num(b_eng_num),
    .eng_data(b_eng_data), .eng_result(b_eng_result),
    .res_valid(b_res_valid), .res_id(b_res_id),
    .res_kind(b_res_kind), .res_idx(b_res_idx),
    .res_data(b_res_data), .res_last(b_res_last)
  );

  // requesters: show-ahead word streams, valid = issued frames not yet served
  logic [7:0] a0_w [64];
  logic [7:0] a1_w [64];
  logic [7:0] b0_w [64];
  bit [5:0] a0_wr, a1_wr, b0_wr;
  bit [5:0] a0_p, a1_p, b0_p;
  int a0_iss, a1_iss, b0_iss;
  int a0_srv, a1_srv, b0_srv;

  assign a_req0_valid = (a0_iss != a0_srv);
  assign a_req1_valid = (a1_iss != a1_srv);
  assign b_req0_valid = (b0_iss != b0_srv);
  assign b_req1_valid = 1'b0;
  assign b_req1_num   = 3'd0;
  assign b_req1_data  = 8'd0;
  assign a_req0_data  = a0_w[a0_p];
  assign a_req1_data  = a1_w[a1_p];
  assign b_req0_data  = b0_w[b0_p];

  always @(posedge clk) begin
    if (a_req0_rd) a0_p <= a0_p + 6'd1;
    if (a_req1_rd) a1_p <= a1_p + 6'd1;
    if (b_req0_rd) b0_p <= b0_p + 6'd1;
    if ((a_req0_rd && a_eng_start) || a_req0_err) a0_srv <= a0_srv + 1;
    if ((a_req1_rd && a_eng_start) || a_req1_err) a1_srv <= a1_srv + 1;
    if ((b_req0_rd && b_eng_start) || b_req0_err) b0_srv <= b0_srv + 1;
  end

  // engine model: sum, max, then the words sorted largest first
  function automatic logic [87:0] calc(input logic [63:0] wp, input int n);
    logic [7:0]  s [8];
    logic [7:0]  t;
    logic [10:0] sum;
    logic [87:0] o;
    sum = '0;
    o   = '0;
    for (int i = 0; i < 8; i++) s[i] = wp[i*8 +: 8];
    for (int i = 0; i < n; i++) sum = sum + 11'(s[i]);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
        if (s[j] < s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    o[10:0]  = sum;
    o[21:11] = {3'b0, s[0]};
    for (int i = 0; i < n; i++) o[(i+2)*11 +: 11] = {3'b0, s[i]};
    return o;
  endfunction

  always @(posedge clk) begin : eng_a
    logic [63:0] wp;
    logic [87:0] r;
    int n, k, d, op;
    bit col, act;
    if (rst) begin
      col = 0; act = 0; k = 0;
      a_eng_result <= '0;
    end else begin
      if (a_eng_start) begin
        n = int'(a_eng_num); wp = '0; wp[7:0] = a_eng_data; k = 1; col = 1;
      end else if (col) begin
        wp[k*8 +: 8] = a_eng_data; k++;
      end
      if (col && k == n) begin
        col = 0; r = calc(wp, n); act = 1; d = 1; op = 0;
      end
      if (act) begin
        if (d > 0) d--;
        else begin
          a_eng_result <= r[op*11 +: 11]; op++;
          if (op == n + 2) act = 0;
        end
      end
    end
  end

  always @(posedge clk) begin : eng_b
    logic [63:0] wp;
    logic [87:0] r;
    int n, k, op;
    bit col, act;
    if (rst) begin
      col = 0; act = 0; k = 0;
      b_eng_result <= '0;
    end else begin
      if (b_eng_start) begin
        n = int'(b_eng_num); wp = '0; wp[7:0] = b_eng_data; k = 1; col = 1;
      end else if (col) begin
        wp[k*8 +: 8] = b_eng_data; k++;
      end
      if (col && k == n) begin
        col = 0; r = calc(wp, n); act = 1; op = 0;
      end
      if (act) begin
        b_eng_result <= r[op*11 +: 11]; op++;
        if (op == n + 2) act = 0;
      end
    end
  end

  // event logs
  res_t qa_res[$];
  res_t qb_res[$];
  int   qa_sc[$];
  logic qa_sid[$];
  int   qa_ec[$];
  logic qa_eid[$];
  int   qb_sc[$];

  always @(negedge clk) begin : mon
    res_t r;
    if (a_eng_start) begin
      qa_sc.push_back(cyc); qa_sid.push_back(a_req1_rd);
    end
    if (a_req0_err || a_req1_err) begin
      qa_ec.push_back(cyc); qa_eid.push_back(a_req1_err);
    end
    if (a_res_valid) begin
      r.cyc = cyc; r.id = a_res_id; r.kind = a_res_kind;
      r.idx = a_res_idx; r.data = a_res_data; r.last = a_res_last;
      qa_res.push_back(r);
    end
    if (b_eng_start) qb_sc.push_back(cyc);
    if (b_res_valid) begin
      r.cyc = cyc; r.id = b_res_id; r.kind = b_res_kind;
      r.idx = b_res_idx; r.data = b_res_data; r.last = b_res_last;
      qb_res.push_back(r);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int exp_d [8];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic issue(input int who, input logic [2:0] n, input int nw,
                       input logic [47:0] wp);
    for (int i = 0; i < nw; i++) begin
      case (who)
        0: begin a0_w[a0_wr] = wp[i*8 +: 8]; a0_wr = a0_wr + 6'd1; end
        1: begin a1_w[a1_wr] = wp[i*8 +: 8]; a1_wr = a1_wr + 6'd1; end
        default: begin b0_w[b0_wr] = wp[i*8 +: 8]; b0_wr = b0_wr + 6'd1; end
      endcase
    end
    case (who)
      0: begin a_req0_num = n; a0_iss++; end
      1: begin a_req1_num = n; a1_iss++; end
      default: begin b_req0_num = n; b0_iss++; end
    endcase
  endtask

  task automatic wait_res(input bit useb, input int target, input int budget);
    int t;
    t = 0;
    while ((useb ? qb_res.size() : qa_res.size()) < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(useb ? "wait_b" : "wait_a",
        32'((useb ? qb_res.size() : qa_res.size()) >= target), 32'd1);
  endtask

  task automatic chk_frame(input string tg, input bit useb, input int base,
                           input int n, input int fc, input int id);
    res_t r;
    for (int j = 0; j < n + 2; j++) begin
      r = useb ? qb_res[base+j] : qa_res[base+j];
      chk({tg, "_cyc"}, r.cyc, fc + j);
      chk({tg, "_data"}, 32'(r.data), exp_d[j]);
      chk({tg, "_kind"}, 32'(r.kind), (j == 0) ? 0 : (j == 1) ? 1 : 2);
      chk({tg, "_idx"}, 32'(r.idx), (j < 2) ? 0 : j - 2);
      chk({tg, "_last"}, 32'(r.last), 32'(j == n + 1));
      chk({tg, "_id"}, 32'(r.id), id);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c, ra, es, ee;
    a_req0_num = 3'd0;
    a_req1_num = 3'd0;
    b_req0_num = 3'd0;

    // both requesters pending through reset, N=2 each
    issue(0, 3'd2, 2, {32'd0, 8'd20, 8'd10});
    issue(1, 3'd2, 2, {32'd0, 8'd40, 8'd30});
    repeat (3) @(negedge clk);
    chk("rst_ctl", {a_req0_rd, a_req1_rd, a_req0_err, a_req1_err,
                    a_eng_start, a_eng_num, a_eng_data, a_res_valid,
                    a_res_id, a_res_kind, a_res_idx}, 0);
    chk("rst_dat", {a_res_data, a_res_last}, 0);
    c = cyc;
    rst = 1'b0;
    wait_res(0, 8, 60);
    chk("rr_start0", qa_sc[0], c + 1);
    chk("rr_id0", 32'(qa_sid[0]), 0);
    chk("rr_start1", qa_sc[1], c + 9);
    chk("rr_id1", 32'(qa_sid[1]), 1);
    exp_d = '{30, 20, 20, 10, 0, 0, 0, 0};
    chk_frame("rr_f0", 0, 0, 2, c + 5, 0);
    exp_d = '{70, 40, 40, 30, 0, 0, 0, 0};
    chk_frame("rr_f1", 0, 4, 2, c + 13, 1);
    repeat (3) @(negedge clk);

    // req1 illegal (7) alongside legal req0 (3)
    ra = qa_res.size(); es = qa_sc.size(); ee = qa_ec.size();
    c = cyc;
    issue(1, 3'd7, 0, 48'd0);
    issue(0, 3'd3, 3, {24'd0, 8'd9, 8'd8, 8'd7});
    wait_res(0, ra + 5, 40);
    repeat (8) @(negedge clk);
    chk("ill_start", qa_sc[es], c + 1);
    chk("ill_start_id", 32'(qa_sid[es]), 0);
    chk("ill_nstart", qa_sc.size() - es, 1);
    chk("ill_nerr", qa_ec.size() - ee, 1);
    chk("ill_err_id", 32'(qa_eid[ee]), 1);
    chk("ill_err_cyc", qa_ec[ee], c + 11);
    exp_d = '{24, 9, 9, 8, 7, 0, 0, 0};
    chk_frame("ill_f", 0, ra, 3, c + 6, 0);

    // req0 only, N=4
    ra = qa_res.size(); es = qa_sc.size();
    c = cyc;
    issue(0, 3'd4, 4, {16'd0, 8'd99, 8'd17, 8'd200, 8'd5});
    wait_res(0, ra + 6, 40);
    chk("n4_start", qa_sc[es], c + 1);
    exp_d = '{321, 200, 200, 99, 17, 5, 0, 0};
    chk_frame("n4", 0, ra, 4, c + 7, 0);
    repeat (3) @(negedge clk);

    // N=6, words 1..6
    ra = qa_res.size();
    c = cyc;
    issue(0, 3'd6, 6, {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    wait_res(0, ra + 8, 50);
    repeat (4) @(negedge clk);
    chk("n6_count", qa_res.size() - ra, 8);
    exp_d = '{21, 6, 6, 5, 4, 3, 2, 1};
    chk_frame("n6", 0, ra, 6, c + 9, 0);

    // reset on the second DRAIN cycle
    ra = qa_res.size();
    c = cyc;
    issue(0, 3'd4, 4, {16'd0, 8'd1, 8'd4, 8'd1, 8'd3});
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctl", {a_req0_rd, a_req1_rd, a_req0_err, a_req1_err,
                        a_eng_start, a_eng_num, a_eng_data, a_res_valid,
                        a_res_id, a_res_kind, a_res_idx}, 0);
    chk("mid_rst_dat", {a_res_data, a_res_last}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_count", qa_res.size() - ra, 1);
    chk("abort_cyc", qa_res[ra].cyc, c + 7);
    chk("abort_data", 32'(qa_res[ra].data), 9);
    chk("abort_last", 32'(qa_res[ra].last), 0);

    // fresh req1 frame after the abort
    ra = qa_res.size(); es = qa_sc.size();
    c = cyc;
    issue(1, 3'd2, 2, {32'd0, 8'd60, 8'd50});
    wait_res(0, ra + 4, 40);
    chk("post_start", qa_sc[es], c + 1);
    chk("post_start_id", 32'(qa_sid[es]), 1);
    exp_d = '{110, 60, 60, 50, 0, 0, 0, 0};
    chk_frame("post", 0, ra, 2, c + 5, 1);
    repeat (3) @(negedge clk);

    // RES_LAT=1 instance, N=3
    c = cyc;
    issue(2, 3'd3, 3, {24'd0, 8'd5, 8'd2, 8'd9});
    wait_res(1, 5, 40);
    chk("l1_start", qb_sc[0], c + 1);
    exp_d = '{16, 9, 9, 5, 2, 0, 0, 0};
    chk_frame("l1", 1, 0, 3, c + 5, 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
